cipher_byte_loader: RTL

CIPHER_BYTE_LOADER -- requirements
Module: cipher_byte_loader

---
 rtl/cipher_byte_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cipher_byte_loader.sv
// cipher_byte_loader: assembles a serial byte stream into a 64-bit key and a
// 64-bit plaintext block, then holds both for the cipher until it is consumed.
// Optional feature macro: CIPHER_KEY_REUSE_EN. When it is defined, asserting
// reuse_key at the output handshake keeps the current key, so the next block
// needs only 8 plaintext bytes.
//
//   state    | meaning
//   LOAD_KEY | accepting 8 key bytes
//   LOAD_PT  | accepting 8 plaintext bytes
//   HOLD     | block complete, out_valid high, waiting for out_ready
module cipher_byte_loader #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reuse_key,
  output logic        out_valid,
  output logic [63:0] out_ptext,
  output logic [63:0] out_key,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    LOAD_KEY = 2'd0,
    LOAD_PT  = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        accept;
  logic        key_shift;
  logic        pt_shift;
  logic        reuse_sel;
  logic [63:0] key_q;
  logic [63:0] ptext_q;

`ifdef CIPHER_KEY_REUSE_EN
  assign reuse_sel = reuse_key;
`else
  logic unused_reuse_key;
  assign unused_reuse_key = reuse_key;
  assign reuse_sel        = 1'b0;
`endif

  // Byte order: MSB_FIRST=1 shifts left so the first byte ends in [63:56];
  // MSB_FIRST=0 shifts right so the first byte ends in [7:0].
  function automatic logic [63:0] shift_in(input logic [63:0] r, input logic [7:0] b);
    if (MSB_FIRST != 0) shift_in = {r[55:0], b};
    else                shift_in = {b, r[63:8]};
  endfunction

  // in_ready is a registered decode, so acceptance never depends on out_ready.
  assign accept = in_valid & in_ready;

  // Next-state, byte counter and shift enables.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_shift = 1'b0;
    pt_shift  = 1'b0;
    case (state)
      LOAD_KEY: begin
        if (accept) begin
          key_shift = 1'b1;
          if (cnt == 3'd7) begin
            cnt_nxt   = 3'd0;
            state_nxt = LOAD_PT;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      LOAD_PT: begin
        if (accept) begin
          pt_shift = 1'b1;
          if (cnt == 3'd7) begin
            cnt_nxt   = 3'd0;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          cnt_nxt   = 3'd0;
          state_nxt = reuse_sel ? LOAD_PT : LOAD_KEY;
        end
      end
      default: begin
        cnt_nxt   = 3'd0;
        state_nxt = LOAD_KEY;
      end
    endcase
  end

  // State, counter, data registers and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_KEY;
      cnt       <= 3'd0;
      key_q     <= 64'd0;
      ptext_q   <= 64'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if (key_shift) key_q   <= shift_in(key_q, in_data);
      if (pt_shift)  ptext_q <= shift_in(ptext_q, in_data);
      in_ready  <= (state_nxt != HOLD);
      out_valid <= (state_nxt == HOLD);
    end
  end

  assign out_key   = key_q;
  assign out_ptext = ptext_q;

endmodule
